// File: rtl/fixed_point_pkg.sv
// Shared types and helpers for the fixed-point divider datapath.
package fixed_point_pkg;

  // Divider sequencing: accept, one quotient bit per cycle, result fix-up, done pulse.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FIX    = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Largest positive two's-complement value for a w-bit word.
  function automatic int max_pos(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  // Most negative two's-complement value for a w-bit word.
  function automatic int min_neg(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/fixed_point_div_step.sv
// One restoring-division iteration: trial subtract of the divisor from the
// already-shifted partial remainder.
module fixed_point_div_step
  import fixed_point_pkg::*;
#(
  parameter int Word_Length = 6
) (
  input  logic [Word_Length:0] i_rem,
  input  logic [Word_Length:0] i_div,
  output logic [Word_Length:0] o_rem,
  output logic                 o_q_bit
);

  logic w_ge;

  // Keep the difference only when it does not go negative; that decision is the quotient bit.
  always_comb begin
    w_ge    = (i_rem >= i_div);
    o_q_bit = w_ge;
    o_rem   = w_ge ? (i_rem - i_div) : i_rem;
  end

endmodule

// File: rtl/fixed_point_divider.sv
// Sequential signed fixed-point divider, Q = A / B in the MAC's Q format.
// Magnitudes are divided with a radix-2 restoring loop (one bit per clock),
// then the sign is applied and the result is saturated to the word range.
module fixed_point_divider
  import fixed_point_pkg::*;
#(
  parameter int Word_Length     = 6,
  parameter int Integer_Part    = 3,
  parameter int Fractional_Part = Word_Length - Integer_Part
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic signed [Word_Length-1:0] A,
  input  logic signed [Word_Length-1:0] B,
  output logic signed [Word_Length-1:0] Q,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow,
  output logic                          div_by_zero
);

  localparam int W  = Word_Length;
  localparam int F  = Fractional_Part;
  // Quotient bits needed: the dividend is pre-scaled by 2^F so the quotient lands in Q format.
  localparam int N  = W + F;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0]        CNT_LAST    = CW'(N - 1);
  localparam logic signed [W-1:0]  MAX_POS     = W'(max_pos(W));
  localparam logic signed [W-1:0]  MIN_NEG     = W'(min_neg(W));
  // Magnitude limits compared against the unsigned quotient.
  localparam logic [N-1:0]         MAG_POS_LIM = N'(max_pos(W));
  localparam logic [N-1:0]         MAG_NEG_LIM = N'(1 << (W - 1));

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]       r_cnt;
  logic [N-1:0]        r_dvd;      // |A| << F, consumed MSB first
  logic [W:0]          r_dvs;      // |B|
  logic [W:0]          r_rem;      // partial remainder, always < |B|
  logic [N-1:0]        r_quo;      // quotient magnitude, filled LSB side
  logic                r_sign;     // sign of the true quotient
  logic                r_sign_a;   // sign of the dividend, selects divide-by-zero saturation
  logic                r_zero;     // divisor was zero at accept

  logic signed [W-1:0] r_q;
  logic                r_ovf;
  logic                r_dz;

  logic                w_accept;
  logic [W:0]          w_a_ext;
  logic [W:0]          w_b_ext;
  logic [W:0]          w_abs_a;
  logic [W:0]          w_abs_b;
  logic [W:0]          w_rem_sh;
  logic [W:0]          w_rem_next;
  logic                w_q_bit;

  logic signed [W-1:0] w_q_fix;
  logic                w_ovf_fix;
  logic                w_dz_fix;

  // Operand magnitudes in W+1 bits so that |-2^(W-1)| is representable.
  always_comb begin
    w_a_ext = {A[W-1], A};
    w_b_ext = {B[W-1], B};
    w_abs_a = A[W-1] ? (~w_a_ext + (W+1)'(1)) : w_a_ext;
    w_abs_b = B[W-1] ? (~w_b_ext + (W+1)'(1)) : w_b_ext;
  end

  assign w_accept = (r_state == IDLE) && start;

  // Shift the remainder left and bring in the next dividend bit. The top
  // remainder bit is always zero here because the remainder stays below |B|.
  assign w_rem_sh = (W+1)'({r_rem, r_dvd[N-1]});

  fixed_point_div_step #(
    .Word_Length (W)
  ) u_step (
    .i_rem   (w_rem_sh),
    .i_div   (r_dvs),
    .o_rem   (w_rem_next),
    .o_q_bit (w_q_bit)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state: start is only honoured in IDLE, so pulses while busy or during DONE are dropped.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = DIVIDE;
      DIVIDE:  if (r_cnt == CNT_LAST) w_next = FIX;
      FIX:     w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Iteration counter: cleared on accept, advanced once per quotient bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (r_state == DIVIDE) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Operand capture at accept, then one restoring step per DIVIDE cycle.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_dvd    <= N'({w_abs_a, {F{1'b0}}});
      r_dvs    <= w_abs_b;
      r_rem    <= '0;
      r_quo    <= '0;
      r_sign   <= A[W-1] ^ B[W-1];
      r_sign_a <= A[W-1];
      r_zero   <= (B == '0);
    end else if (r_state == DIVIDE) begin
      r_dvd <= r_dvd << 1;
      r_rem <= w_rem_next;
      r_quo <= {r_quo[N-2:0], w_q_bit};
    end
  end

  // Sign application and saturation. A negative result may reach -2^(W-1)
  // exactly; a positive one stops at 2^(W-1)-1.
  always_comb begin
    w_q_fix   = '0;
    w_ovf_fix = 1'b0;
    w_dz_fix  = 1'b0;
    if (r_zero) begin
      w_q_fix  = r_sign_a ? MIN_NEG : MAX_POS;
      w_dz_fix = 1'b1;
    end else if (!r_sign) begin
      if (r_quo > MAG_POS_LIM) begin
        w_q_fix   = MAX_POS;
        w_ovf_fix = 1'b1;
      end else begin
        w_q_fix = $signed(r_quo[W-1:0]);
      end
    end else begin
      if (r_quo > MAG_NEG_LIM) begin
        w_q_fix   = MIN_NEG;
        w_ovf_fix = 1'b1;
      end else begin
        // Magnitude 2^(W-1) wraps to itself on negation, which is the intended most-negative code.
        w_q_fix = -$signed(r_quo[W-1:0]);
      end
    end
  end

  // Result registers: loaded in FIX, held until the next operation's FIX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q   <= '0;
      r_ovf <= 1'b0;
      r_dz  <= 1'b0;
    end else if (r_state == FIX) begin
      r_q   <= w_q_fix;
      r_ovf <= w_ovf_fix;
      r_dz  <= w_dz_fix;
    end
  end

  assign Q           = r_q;
  assign overflow    = r_ovf;
  assign div_by_zero = r_dz;
  assign busy        = (r_state == DIVIDE) || (r_state == FIX);
  assign done        = (r_state == DONE);

endmodule

// File: tb/tb_fixed_point_divider.sv
// Self-checking bench for fixed_point_divider (defaults W=6, Q3.3).
module tb_fixed_point_divider;

  localparam int W   = 6;
  localparam int F   = 3;
  localparam int LAT = 11;   // cycles from the start cycle to the done cycle
  localparam int MAXP = (1 << (W - 1)) - 1;
  localparam int MINN = -(1 << (W - 1));

  logic                clk;
  logic                reset;
  logic                start;
  logic signed [W-1:0] A;
  logic signed [W-1:0] B;
  logic signed [W-1:0] Q;
  logic                busy;
  logic                done;
  logic                overflow;
  logic                div_by_zero;

  int n_vec;
  int n_err;

  fixed_point_divider #(
    .Word_Length     (W),
    .Integer_Part    (W - F),
    .Fractional_Part (F)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .A           (A),
    .B           (B),
    .Q           (Q),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: real-valued quotient of two Q-format codes, truncated toward zero, then saturated.
  function automatic void ref_div(input int a, input int b, output int q, output bit ov, output bit dz);
    int mag;
    bit neg;
    ov = 1'b0;
    dz = 1'b0;
    if (b == 0) begin
      dz = 1'b1;
      q  = (a < 0) ? MINN : MAXP;
      return;
    end
    neg = (a < 0) != (b < 0);
    mag = ((a < 0 ? -a : a) * (1 << F)) / (b < 0 ? -b : b);
    if (!neg) begin
      if (mag > MAXP) begin q = MAXP; ov = 1'b1; end
      else q = mag;
    end else begin
      if (mag > -MINN) begin q = MINN; ov = 1'b1; end
      else q = -mag;
    end
  endfunction

  // Issue one start pulse and wait (bounded) for done; lat is the start-to-done cycle count.
  task automatic drive_op(input int a, input int b, output int lat);
    A = W'(a);
    B = W'(b);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({Q, busy, done, overflow, div_by_zero} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got Q=%0d busy=%b done=%b ovf=%b dz=%b required all 0",
               $signed(Q), busy, done, overflow, div_by_zero);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: got busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    int ta [10] = '{20, 8, -8, -32, 24, -8, -32, 31, -32, 4};
    int tb [10] = '{8, 24, 4, 8, 2, 0, -8, 0, -1, -8};
    int tq [10] = '{20, 2, -16, -32, 31, -32, 31, 31, 31, -4};
    bit tov[10] = '{0, 0, 0, 0, 1, 0, 1, 0, 1, 0};
    bit tdz[10] = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 0};
    int lat;
    for (int i = 0; i < 10; i++) begin
      drive_op(ta[i], tb[i], lat);
      n_vec++;
      if (lat !== LAT) begin
        n_err++;
        $display("FAIL dir_latency[%0d]: got %0d cycles required %0d", i, lat, LAT);
      end
      n_vec++;
      if (Q !== W'(tq[i]) || overflow !== tov[i] || div_by_zero !== tdz[i]) begin
        n_err++;
        $display("FAIL dir_result[%0d] A=%0d B=%0d: got Q=%0d ovf=%b dz=%b required Q=%0d ovf=%b dz=%b",
                 i, ta[i], tb[i], $signed(Q), overflow, div_by_zero, tq[i], tov[i], tdz[i]);
      end
      @(posedge clk); #1;
      n_vec++;
      if (done !== 1'b0 || busy !== 1'b0 || Q !== W'(tq[i])) begin
        n_err++;
        $display("FAIL dir_after_done[%0d]: got done=%b busy=%b Q=%0d required 0 0 %0d",
                 i, done, busy, $signed(Q), tq[i]);
      end
    end
  endtask

  task automatic test_random();
    int a, b, q, lat;
    bit ov, dz;
    for (int i = 0; i < 40; i++) begin
      a = int'($signed(W'($urandom_range(0, (1 << W) - 1))));
      b = (i % 13 == 5) ? 0 : int'($signed(W'($urandom_range(0, (1 << W) - 1))));
      ref_div(a, b, q, ov, dz);
      drive_op(a, b, lat);
      n_vec++;
      if (lat !== LAT || Q !== W'(q) || overflow !== ov || div_by_zero !== dz) begin
        n_err++;
        $display("FAIL rand[%0d] A=%0d B=%0d: got lat=%0d Q=%0d ovf=%b dz=%b required lat=%0d Q=%0d ovf=%b dz=%b",
                 i, a, b, lat, $signed(Q), overflow, div_by_zero, LAT, q, ov, dz);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_restart_ignored();
    int lat;
    A = W'(20);
    B = W'(8);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      if (lat == 4) begin
        A = W'(-8);
        B = '0;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    n_vec++;
    if (lat !== LAT || Q !== W'(20) || overflow !== 1'b0 || div_by_zero !== 1'b0) begin
      n_err++;
      $display("FAIL restart_mid_divide: got lat=%0d Q=%0d ovf=%b dz=%b required lat=%0d Q=20 ovf=0 dz=0",
               lat, $signed(Q), overflow, div_by_zero, LAT);
    end
    // start during the done cycle must be dropped
    A = W'(24);
    B = W'(2);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL start_in_done: got busy=%b required 0", busy);
    end
    @(posedge clk); #1;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || Q !== W'(20)) begin
      n_err++;
      $display("FAIL start_in_done_idle: got busy=%b done=%b Q=%0d required 0 0 20", busy, done, $signed(Q));
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    bit seen_done;
    drive_op(-8, 4, lat);
    @(posedge clk); #1;
    A = W'(24);
    B = W'(2);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (busy !== 1'b1 || Q !== W'(-16)) begin
      n_err++;
      $display("FAIL abort_precondition: got busy=%b Q=%0d required 1 -16", busy, $signed(Q));
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if ({Q, busy, done, overflow, div_by_zero} !== '0) begin
      n_err++;
      $display("FAIL abort_outputs: got Q=%0d busy=%b done=%b ovf=%b dz=%b required all 0",
               $signed(Q), busy, done, overflow, div_by_zero);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    seen_done = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    n_vec++;
    if (seen_done !== 1'b0) begin
      n_err++;
      $display("FAIL abort_no_done: got activity=%b required 0", seen_done);
    end
    drive_op(8, 24, lat);
    n_vec++;
    if (lat !== LAT || Q !== W'(2) || overflow !== 1'b0 || div_by_zero !== 1'b0) begin
      n_err++;
      $display("FAIL abort_recover: got lat=%0d Q=%0d ovf=%b dz=%b required lat=%0d Q=2 0 0",
               lat, $signed(Q), overflow, div_by_zero, LAT);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_hold();
    int lat;
    drive_op(-32, 8, lat);
    repeat (5) @(posedge clk);
    #1;
    n_vec++;
    if (Q !== W'(-32) || overflow !== 1'b0 || div_by_zero !== 1'b0) begin
      n_err++;
      $display("FAIL hold_idle: got Q=%0d ovf=%b dz=%b required -32 0 0", $signed(Q), overflow, div_by_zero);
    end
    A = W'(24);
    B = W'(2);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_vec++;
    if (busy !== 1'b1 || Q !== W'(-32) || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL hold_busy: got busy=%b Q=%0d ovf=%b required 1 -32 0", busy, $signed(Q), overflow);
    end
    lat = 6;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    n_vec++;
    if (lat !== LAT || Q !== W'(31) || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL hold_next: got lat=%0d Q=%0d ovf=%b required lat=%0d Q=31 ovf=1", lat, $signed(Q), overflow, LAT);
    end
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (Q !== W'(31) || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL hold_flag: got Q=%0d ovf=%b required 31 1", $signed(Q), overflow);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_directed();
    test_random();
    test_restart_ignored();
    test_reset_abort();
    test_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
